// File: rtl/sddac_interp.sv
// Linear interpolating upsampler feeding a sigma-delta DAC: accepts Q(1,15) samples
// over valid/ready and emits one interpolated sample per clock, flagging underruns.
module sddac_interp #(
    parameter int OSR_LOG2 = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        clr_underrun,
    output logic [15:0] sig_out,
    output logic        phase_start,
    output logic        underrun
);

    localparam int AW = 17 + OSR_LOG2;
    localparam logic [OSR_LOG2-1:0] LAST = '1;

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [15:0]          nxt;
    logic                 nxt_valid;
    logic [15:0]          target;
    logic [16:0]          delta;
    logic [AW-1:0]        acc;
    logic [OSR_LOG2-1:0]  cnt;
    logic                 load;
    logic                 set_ur;
    logic                 accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        set_ur    = 1'b0;
        case (state)
            IDLE: begin
                if (nxt_valid) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    if (nxt_valid) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = HOLD;
                        set_ur    = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (nxt_valid) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready    = !nxt_valid && !rst;
        phase_start = (state == RUN) && (cnt == '0);
        sig_out     = acc[OSR_LOG2 +: 16];
        accept      = in_valid && !nxt_valid;
    end

    // A load needs a full buffer while an accept needs an empty one, so the two
    // updates to nxt_valid below are mutually exclusive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nxt       <= '0;
            nxt_valid <= 1'b0;
            target    <= '0;
            delta     <= '0;
            acc       <= '0;
            cnt       <= '0;
            underrun  <= 1'b0;
        end else begin
            if (accept) begin
                nxt       <= in_data;
                nxt_valid <= 1'b1;
            end
            if (load) begin
                delta     <= {nxt[15], nxt} - {target[15], target};
                target    <= nxt;
                acc       <= {target[15], target, {OSR_LOG2{1'b0}}};
                cnt       <= '0;
                nxt_valid <= 1'b0;
            end else if (state == RUN) begin
                // Snapping to the endpoint on the last step equals acc+delta exactly.
                if (cnt == LAST) begin
                    acc <= {target[15], target, {OSR_LOG2{1'b0}}};
                end else begin
                    acc <= acc + {{OSR_LOG2{delta[16]}}, delta};
                end
                cnt <= cnt + 1'b1;
            end
            if (set_ur) begin
                underrun <= 1'b1;
            end else if (clr_underrun) begin
                underrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sddac_interp.sv
// Self-checking bench for sddac_interp at OSR_LOG2=2: directed table, back-to-back
// handshake, reset mid-segment and randomized traffic against a segment-level model.
module tb_sddac_interp;

    localparam int L   = 2;
    localparam int OSR = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        clr_underrun = 1'b0;
    logic        in_ready;
    logic [15:0] sig_out;
    logic        phase_start;
    logic        underrun;

    int vectors = 0;
    int miscompares = 0;

    sddac_interp #(.OSR_LOG2(L)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .clr_underrun (clr_underrun),
        .sig_out      (sig_out),
        .phase_start  (phase_start),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] din;
        logic        vld;
        logic        clr;
        logic [15:0] sig;
        logic        ph;
        logic        ur;
        logic        rdy;
    } vec_t;

    vec_t tbl[28];

    function automatic vec_t mk(logic [15:0] din, logic vld, logic clr,
                                logic [15:0] sig, logic ph, logic ur, logic rdy);
        vec_t v;
        v.din = din; v.vld = vld; v.clr = clr;
        v.sig = sig; v.ph = ph; v.ur = ur; v.rdy = rdy;
        return v;
    endfunction

    // Model: mode 0 idle, 1 ramping, 2 holding; output is start + floor(k*(target-start)/OSR).
    int m_mode, m_target, m_start, m_k, m_buf;
    bit m_full, m_ur;

    function automatic int fdiv(int a);
        if (a >= 0) return a / OSR;
        return -((-a + OSR - 1) / OSR);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_target = 0; m_start = 0; m_k = 0; m_buf = 0;
        m_full = 0; m_ur = 0;
    endtask

    task automatic model_load();
        m_start  = m_target;
        m_target = m_buf;
        m_k      = 0;
        m_full   = 0;
        m_mode   = 1;
    endtask

    task automatic model_edge();
        bit take;
        bit set;
        take = in_valid && !m_full;
        set  = 0;
        if (m_mode == 1) begin
            if (m_k == OSR - 1) begin
                if (m_full) model_load();
                else begin
                    m_mode = 2;
                    set    = 1;
                end
            end else begin
                m_k++;
            end
        end else if (m_full) begin
            model_load();
        end
        if (take) begin
            m_buf  = int'($signed(in_data));
            m_full = 1;
        end
        if (set) m_ur = 1;
        else if (clr_underrun) m_ur = 0;
    endtask

    function automatic logic [15:0] model_sig();
        int v;
        v = (m_mode == 1) ? m_start + fdiv(m_k * (m_target - m_start)) : m_target;
        return v[15:0];
    endfunction

    task automatic chk(string name, logic [15:0] got, logic [15:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic check_model(string tag);
        chk({tag, "_sig"},   sig_out,            model_sig());
        chk({tag, "_phase"}, 16'(phase_start),   16'(m_mode == 1 && m_k == 0));
        chk({tag, "_ur"},    16'(underrun),      16'(m_ur));
        chk({tag, "_ready"}, 16'(in_ready),      16'(!m_full));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        int rcount;
        int pcount;
        bit ur_seen;

        tbl[0]  = mk(16'h4000, 1, 0, 16'h0000, 0, 0, 0);
        tbl[1]  = mk(16'h0000, 0, 0, 16'h0000, 1, 0, 1);
        tbl[2]  = mk(16'h0000, 0, 0, 16'h1000, 0, 0, 1);
        tbl[3]  = mk(16'h0000, 0, 0, 16'h2000, 0, 0, 1);
        tbl[4]  = mk(16'h0000, 0, 0, 16'h3000, 0, 0, 1);
        tbl[5]  = mk(16'h0000, 0, 0, 16'h4000, 0, 1, 1);
        tbl[6]  = mk(16'hC000, 1, 1, 16'h4000, 0, 0, 0);
        tbl[7]  = mk(16'h0000, 0, 0, 16'h4000, 1, 0, 1);
        tbl[8]  = mk(16'h4000, 1, 0, 16'h2000, 0, 0, 0);
        tbl[9]  = mk(16'h0000, 0, 0, 16'h0000, 0, 0, 0);
        tbl[10] = mk(16'h0000, 0, 0, 16'hE000, 0, 0, 0);
        tbl[11] = mk(16'h0000, 0, 0, 16'hC000, 1, 0, 1);
        tbl[12] = mk(16'h0000, 0, 0, 16'hE000, 0, 0, 1);
        tbl[13] = mk(16'h0000, 0, 0, 16'h0000, 0, 0, 1);
        tbl[14] = mk(16'h0000, 0, 0, 16'h2000, 0, 0, 1);
        tbl[15] = mk(16'h0000, 0, 0, 16'h4000, 0, 1, 1);
        tbl[16] = mk(16'h7FFF, 1, 1, 16'h4000, 0, 0, 0);
        tbl[17] = mk(16'h0000, 0, 0, 16'h4000, 1, 0, 1);
        tbl[18] = mk(16'h8000, 1, 0, 16'h4FFF, 0, 0, 0);
        tbl[19] = mk(16'h0000, 0, 0, 16'h5FFF, 0, 0, 0);
        tbl[20] = mk(16'h0000, 0, 0, 16'h6FFF, 0, 0, 0);
        tbl[21] = mk(16'h0000, 0, 0, 16'h7FFF, 1, 0, 1);
        tbl[22] = mk(16'h0000, 0, 0, 16'h3FFF, 0, 0, 1);
        tbl[23] = mk(16'h0000, 0, 0, 16'hFFFF, 0, 0, 1);
        tbl[24] = mk(16'h0000, 0, 0, 16'hBFFF, 0, 0, 1);
        tbl[25] = mk(16'h0000, 0, 1, 16'h8000, 0, 1, 1);
        tbl[26] = mk(16'h0000, 0, 1, 16'h8000, 0, 0, 1);
        tbl[27] = mk(16'h0000, 0, 0, 16'h8000, 0, 0, 1);

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_sig",   sig_out,          16'h0000);
        chk("reset_phase", 16'(phase_start), 16'h0000);
        chk("reset_ur",    16'(underrun),    16'h0000);
        chk("reset_ready", 16'(in_ready),    16'h0000);
        rst = 1'b0;
        #1;
        chk("release_ready", 16'(in_ready), 16'h0001);

        for (int i = 0; i < 28; i++) begin
            in_data      = tbl[i].din;
            in_valid     = tbl[i].vld;
            clr_underrun = tbl[i].clr;
            step();
            chk($sformatf("tbl%0d_sig", i),   sig_out,          tbl[i].sig);
            chk($sformatf("tbl%0d_phase", i), 16'(phase_start), 16'(tbl[i].ph));
            chk($sformatf("tbl%0d_ur", i),    16'(underrun),    16'(tbl[i].ur));
            chk($sformatf("tbl%0d_ready", i), 16'(in_ready),    16'(tbl[i].rdy));
        end
        clr_underrun = 1'b0;

        // Back-to-back: in_valid held high continuously.
        in_valid = 1'b1;
        rcount = 0;
        pcount = 0;
        ur_seen = 0;
        for (int i = 0; i < 36; i++) begin
            in_data = 16'($urandom);
            step();
            check_model("b2b");
            if (i >= 4) begin
                if (in_ready) rcount++;
                if (phase_start) pcount++;
                if (underrun) ur_seen = 1;
            end
        end
        chk("b2b_ready_count", 16'(rcount),  16'd8);
        chk("b2b_phase_count", 16'(pcount),  16'd8);
        chk("b2b_no_underrun", 16'(ur_seen), 16'd0);

        // Reset mid-segment with a buffered sample.
        chk("pre_rst_buffered", 16'(in_ready), 16'h0000);
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("midrst_sig",   sig_out,          16'h0000);
        chk("midrst_ready", 16'(in_ready),    16'h0000);
        chk("midrst_phase", 16'(phase_start), 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        chk("postrst_ready", 16'(in_ready), 16'h0001);
        in_data  = 16'h2000;
        in_valid = 1'b1;
        step();
        check_model("postrst");
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check_model("postrst");
        end

        // Randomized traffic: sparse phase provokes underruns, dense phase sustains.
        for (int i = 0; i < 400; i++) begin
            in_data      = 16'($urandom);
            in_valid     = (i < 200) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 8);
            clr_underrun = ($urandom_range(0, 15) == 0);
            step();
            check_model("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
